// File: rtl/vin_adapter.sv
// DPI luma to 16-bit pixel-pair adapter with output FIFO for the EPD controller.
// Define VIN_TIMING_CHECK_EN to build the line/frame length checker that drives timing_err.
module vin_adapter #(
    parameter int unsigned PIX_PER_LINE = 800,
    parameter int unsigned LINES        = 1200,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dpi_vsync,
    input  logic        dpi_de,
    input  logic [7:0]  dpi_y,
    output logic        vin_vsync,
    output logic [15:0] vin_pixel,
    output logic        vin_valid,
    input  logic        vin_ready,
    output logic        overflow,
    output logic        timing_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [1:0] ST_VBLANK = 2'd0;
    localparam logic [1:0] ST_EVEN   = 2'd1;
    localparam logic [1:0] ST_ODD    = 2'd2;

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        (PIX_PER_LINE % 2) != 0 || LINES == 0) begin : g_param_check
        $error("vin_adapter: illegal parameter set");
    end

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [7:0]    low_q;
    logic [7:0]    low_nxt;
    logic          push;
    logic [15:0]   push_data;
    logic          vs_rise;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_nxt;
    logic [PW-1:0] rd_nxt;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic          valid_nxt;
    logic [15:0]   pixel_nxt;

    assign vs_rise = dpi_vsync & ~vin_vsync;

    // Pack FSM: pair consecutive luma samples, pad an odd trailing sample with zero.
    always_comb begin
        state_nxt = state;
        low_nxt   = low_q;
        push      = 1'b0;
        push_data = 16'h0000;
        if (vs_rise) begin
            state_nxt = ST_VBLANK;
        end else begin
            case (state)
                ST_VBLANK: begin
                    if (!dpi_vsync) state_nxt = ST_EVEN;
                end
                ST_EVEN: begin
                    if (dpi_de) begin
                        low_nxt   = dpi_y;
                        state_nxt = ST_ODD;
                    end
                end
                ST_ODD: begin
                    push      = 1'b1;
                    state_nxt = ST_EVEN;
                    push_data = dpi_de ? {dpi_y, low_q} : {8'h00, low_q};
                end
                default: state_nxt = ST_VBLANK;
            endcase
        end
    end

    // FIFO bookkeeping; vin_valid mirrors non-empty so pop needs no extra qualifier.
    always_comb begin
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop       = vin_valid & vin_ready;
        push_ok   = push & (~full | pop);
        drop      = push & full & ~pop;
        wr_nxt    = vs_rise ? PW'(0) : wr_ptr + PW'(push_ok);
        rd_nxt    = vs_rise ? PW'(0) : rd_ptr + PW'(pop);
        valid_nxt = (wr_nxt != rd_nxt);
        // The new head is the word being written only when the FIFO drains to empty this cycle.
        if (push_ok && (rd_nxt[AW-1:0] == wr_ptr[AW-1:0]))
            pixel_nxt = push_data;
        else
            pixel_nxt = mem[rd_nxt[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_VBLANK;
            low_q     <= 8'h00;
            wr_ptr    <= PW'(0);
            rd_ptr    <= PW'(0);
            vin_valid <= 1'b0;
            vin_pixel <= 16'h0000;
            vin_vsync <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            low_q     <= low_nxt;
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            vin_valid <= valid_nxt;
            vin_vsync <= dpi_vsync;
            if (valid_nxt) vin_pixel <= pixel_nxt;
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef VIN_TIMING_CHECK_EN
    localparam int unsigned WCW = $clog2(PIX_PER_LINE / 2 + 1) + 1;
    localparam int unsigned LCW = $clog2(LINES + 1) + 1;

    logic           de_q;
    logic           de_fall;
    logic           frame_seen;
    logic [WCW-1:0] word_cnt;
    logic [WCW-1:0] words_now;
    logic [LCW-1:0] line_cnt;

    assign de_fall = de_q & ~dpi_de;

    // Counters saturate so an overlong line or frame can never wrap back to a legal count.
    always_comb begin
        words_now = word_cnt;
        if (push && (word_cnt != {WCW{1'b1}})) words_now = word_cnt + WCW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            de_q       <= 1'b0;
            frame_seen <= 1'b0;
            word_cnt   <= WCW'(0);
            line_cnt   <= LCW'(0);
            timing_err <= 1'b0;
        end else begin
            de_q <= dpi_de;
            if (vs_rise) begin
                if (frame_seen && (line_cnt != LCW'(LINES))) timing_err <= 1'b1;
                frame_seen <= 1'b1;
                word_cnt   <= WCW'(0);
                line_cnt   <= LCW'(0);
            end else if (de_fall) begin
                if (words_now != WCW'(PIX_PER_LINE / 2)) timing_err <= 1'b1;
                word_cnt <= WCW'(0);
                if (line_cnt != {LCW{1'b1}}) line_cnt <= line_cnt + LCW'(1);
            end else begin
                word_cnt <= words_now;
            end
        end
    end
`else
    assign timing_err = 1'b0;
`endif

endmodule

// File: doc/vin_adapter.md
VIN_ADAPTER -- requirements
Module: vin_adapter

Interface
REQ-001 Parameter: PIX_PER_LINE, 800, active luma pixels per line (even; 400 words per line).
REQ-002 Parameter: LINES, 1200, active lines per frame.
REQ-003 Parameter: FIFO_DEPTH, 16, output FIFO words (power of two, >= 4).
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset (asserted when 0).
REQ-006 dpi_vsync  in  1  source vertical sync, active-high.
REQ-007 dpi_de  in  1  source data enable, one luma pixel per cycle while high.
REQ-008 dpi_y  in  8  luma pixel.
REQ-009 vin_vsync  out  1  vsync to the EPD controller, registered copy of dpi_vsync.
REQ-010 vin_pixel  out  16  packed pixel pair, first pixel [7:0], second [15:8].
REQ-011 vin_valid  out  1  vin_pixel holds a valid word.
REQ-012 vin_ready  in  1  consumer accepts the word when vin_valid and vin_ready are both high.
REQ-013 overflow  out  1  sticky: a word was dropped because the FIFO was full.
REQ-014 timing_err  out  1  sticky: a line or frame length mismatch was detected.

Function
REQ-015 The pack FSM SHALL have three states: VBLANK, EVEN (no pixel held) and ODD (low byte held).
REQ-016 VBLANK SHALL go to EVEN on the first cycle with dpi_vsync=0.
REQ-017 EVEN with dpi_de=1 SHALL latch dpi_y into the low byte and go to ODD.
REQ-018 ODD with dpi_de=1 SHALL form {dpi_y, low byte}, push it to the FIFO and go to EVEN.
REQ-019 ODD with dpi_de=0 (odd-length line) SHALL push {8'h00, low byte}, go to EVEN and count as a short line.
REQ-020 A dpi_vsync rising edge in any state SHALL go to VBLANK, flush the FIFO, discard any held byte and clear the word and line counters.
REQ-021 vin_vsync SHALL equal dpi_vsync delayed by exactly one cycle.
REQ-022 A pushed word SHALL appear on vin_pixel with vin_valid=1 one cycle after the push cycle when the FIFO was empty; there is no same-cycle bypass.
REQ-023 vin_valid SHALL be high exactly when the FIFO is non-empty.
REQ-024 While vin_valid=1 and vin_ready=0, vin_pixel SHALL stay stable.
REQ-025 A push into a full FIFO in a cycle with no pop SHALL drop the word, leave the FIFO contents unchanged and set overflow.
REQ-026 A push and a pop in the same cycle on a full FIFO SHALL both take effect, with no overflow.
REQ-027 Push and pop in the same cycle on an empty FIFO: only the push SHALL take effect.
REQ-028 The FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full and empty are derived from the MSB and the remaining bits.
REQ-029 The word counter SHALL count words pushed in the current line; on a dpi_de falling edge a count other than PIX_PER_LINE/2 SHALL set timing_err.
REQ-030 The line counter SHALL count dpi_de falling edges; on a dpi_vsync rising edge a count other than LINES SHALL set timing_err.
REQ-031 The first vsync after reset SHALL NOT trigger the frame-length check.

Reset
REQ-032 rst=0 at a rising edge SHALL set: FSM=VBLANK, FIFO empty, vin_valid=0, vin_pixel=16'h0000, vin_vsync=0, overflow=0, timing_err=0, all counters 0.
REQ-033 Reset asserted mid-line SHALL discard held and queued data; no partial word is emitted after release.
REQ-034 The sticky flags SHALL be cleared only by reset.

Configuration
REQ-035 Macro VIN_TIMING_CHECK_EN: when defined, REQ-029 to REQ-031 apply.
REQ-036 When VIN_TIMING_CHECK_EN is not defined, the word and line counters SHALL be omitted and timing_err tied to 0; all other behaviour is unchanged.

Verification
REQ-037 Pixels 0x11,0x22 with dpi_de high, vin_ready=1 -> vin_pixel=16'h2211, vin_valid=1 for one cycle, exactly one cycle after 0x22 is sampled.
REQ-038 vin_ready=0 while 40 pixels (20 words) are streamed into FIFO_DEPTH=16 -> 16 words held, overflow=1; then vin_ready=1 -> first 16 words emerge in order and vin_valid drops.
REQ-039 3-pixel line 0xA1,0xB2,0xC3 -> words 16'hB2A1 then 16'h00C3; timing_err=1 (macro defined) or 0 (macro undefined).
REQ-040 dpi_vsync raised while 5 words are queued -> vin_valid=0 on the next cycle, vin_vsync=1 one cycle after dpi_vsync.
REQ-041 Full frame of 1200 lines x 800 pixels, vin_ready=1 -> 480000 words out, overflow=0, timing_err=0.
REQ-042 rst=0 for one cycle mid-line with 3 words queued -> all outputs at reset values next cycle; no stale word after release.
